motor_pwm_ctrl: RTL

Multi-channel motor speed controller. It latches a per-motor speed command, maps it to a banded PWM duty target and ramps each channel's duty toward that target at a fixed slew rate. It drives one PWM line per motor from a shared free-running counter. It sits between the speed/selection command source and the motor driver stage, and extends the single-selector, combinational speed-code decoder to N independently ramped channels.

---
 rtl/motor_pwm_ctrl_if.sv | 23 ++
 rtl/motor_pwm_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/motor_pwm_ctrl_if.sv
// Command bus between the speed/selection source and motor_pwm_ctrl.
// The command source drives select/speed/load/estop and receives err/motor_active.
interface motor_pwm_ctrl_if #(
  parameter int SEL_W   = 2,
  parameter int SPEED_W = 4
) ();
  logic [SEL_W-1:0]   sel;
  logic [SPEED_W-1:0] speed_cmd;
  logic               load;
  logic               estop;
  logic               err;
  logic [SEL_W:0]     motor_active;

  modport master (
    output sel, speed_cmd, load, estop,
    input  err, motor_active
  );

  modport slave (
    input  sel, speed_cmd, load, estop,
    output err, motor_active
  );
endinterface

// File: rtl/motor_pwm_ctrl.sv
// N-channel motor PWM controller: banded speed targets, slew-limited duty ramps
// and one PWM line per channel compared against a shared free-running counter.
module motor_pwm_ctrl #(
  parameter int N_MOTORS  = 4,
  parameter int SEL_W     = 2,
  parameter int SPEED_W   = 4,
  parameter int PWM_W     = 8,
  parameter int TH_MID    = 3,
  parameter int TH_HIGH   = 8,
  parameter logic [PWM_W-1:0] DUTY_LOW  = 8'h0F,
  parameter logic [PWM_W-1:0] DUTY_MID  = 8'h33,
  parameter logic [PWM_W-1:0] DUTY_HIGH = 8'hC3,
  parameter int RAMP_DIV  = 16,
  parameter int RAMP_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  motor_pwm_ctrl_if.slave      cmd,
  output logic [N_MOTORS-1:0]  pwm_out,
  output logic [N_MOTORS-1:0]  busy
);
  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_W-1:0] STEP = PWM_W'(RAMP_STEP);

  logic [PRE_W-1:0]                 presc_reg;
  logic [PWM_W-1:0]                 pcnt_reg;
  logic [N_MOTORS-1:0][PWM_W-1:0]   tgt_reg;
  logic [N_MOTORS-1:0][PWM_W-1:0]   cur_reg;
  logic [N_MOTORS-1:0][PWM_W-1:0]   cur_next;
  logic                             tick;
  logic                             sel_in_range;
  logic                             load_ok;
  logic                             load_bad;
  logic [PWM_W-1:0]                 band_duty;

  function automatic logic [PWM_W-1:0] band(input logic [SPEED_W-1:0] s);
    if (s == '0)                 return '0;
    else if (int'(s) < TH_MID)   return DUTY_LOW;
    else if (int'(s) < TH_HIGH)  return DUTY_MID;
    else                         return DUTY_HIGH;
  endfunction

  assign tick         = (presc_reg == PRE_W'(RAMP_DIV - 1));
  assign sel_in_range = ({1'b0, cmd.sel} < (SEL_W+1)'(N_MOTORS));
  assign load_ok      = cmd.load && !cmd.estop && sel_in_range;
  assign load_bad     = cmd.load && !cmd.estop && !sel_in_range;
  assign band_duty    = band(cmd.speed_cmd);

  // Clamp each step at the target so the ramp can neither overshoot nor wrap.
  generate
    for (genvar gi = 0; gi < N_MOTORS; gi++) begin : gen_ch
      always_comb begin
        cur_next[gi] = cur_reg[gi];
        if (cur_reg[gi] < tgt_reg[gi]) begin
          cur_next[gi] = (tgt_reg[gi] - cur_reg[gi] > STEP) ? cur_reg[gi] + STEP : tgt_reg[gi];
        end else if (cur_reg[gi] > tgt_reg[gi]) begin
          cur_next[gi] = (cur_reg[gi] - tgt_reg[gi] > STEP) ? cur_reg[gi] - STEP : tgt_reg[gi];
        end
      end
      assign busy[gi] = (cur_reg[gi] != tgt_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg        <= '0;
      pcnt_reg         <= '0;
      tgt_reg          <= '0;
      cur_reg          <= '0;
      pwm_out          <= '0;
      cmd.motor_active <= '0;
      cmd.err          <= 1'b0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      pcnt_reg  <= pcnt_reg + 1'b1;
      cmd.err   <= load_bad;
      if (cmd.estop) begin
        tgt_reg <= '0;
        cur_reg <= '0;
        pwm_out <= '0;
      end else begin
        if (load_ok) begin
          cmd.motor_active <= {1'b0, cmd.sel} + (SEL_W+1)'(1);
        end
        // A load coinciding with a tick steps toward the old target; new target applies next tick.
        for (int i = 0; i < N_MOTORS; i++) begin
          if (tick) begin
            cur_reg[i] <= cur_next[i];
          end
          if (load_ok && int'(cmd.sel) == i) begin
            tgt_reg[i] <= band_duty;
          end
          pwm_out[i] <= (cur_reg[i] > pcnt_reg);
        end
      end
    end
  end
endmodule
